// File: rtl/execute_if.sv
// rtl/execute_if.sv - EX-stage operand/result bundle between pipeline control and the ALU
interface execute_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] AluReadData1;
    logic [WIDTH-1:0] AluReadData2;
    logic [WIDTH-1:0] Immediate;
    logic [5:0]       funct;
    logic [2:0]       ALUOp;
    logic             ALUSrc;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;

    modport master (
        output AluReadData1, AluReadData2, Immediate, funct, ALUOp, ALUSrc,
        input  ALUResult, Zero, Busy
    );

    modport slave (
        input  AluReadData1, AluReadData2, Immediate, funct, ALUOp, ALUSrc,
        output ALUResult, Zero, Busy
    );
endinterface

// File: rtl/execute.sv
// rtl/execute.sv - MIPS EX stage: combinational ALU plus sequential Booth MULT when EXECUTE_MUL_EN is defined
module execute #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic      clk,
    input  logic      rst,
    execute_if.slave  bus
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_comb;
    logic [WIDTH-1:0] result;

    assign a = bus.AluReadData1;
    assign b = bus.ALUSrc ? bus.Immediate : bus.AluReadData2;

    always_comb begin
        alu_comb = '0;
        case (bus.ALUOp)
            3'd0: alu_comb = a + b;
            3'd1: alu_comb = a - b;
            3'd2: begin
                case (bus.funct)
                    6'h20, 6'h21: alu_comb = a + b;
                    6'h22, 6'h23: alu_comb = a - b;
                    6'h24:        alu_comb = a & b;
                    6'h25:        alu_comb = a | b;
                    6'h26:        alu_comb = a ^ b;
                    6'h27:        alu_comb = ~(a | b);
                    6'h2A:        alu_comb = WIDTH'($signed(a) < $signed(b));
                    6'h2B:        alu_comb = WIDTH'(a < b);
                    default:      alu_comb = '0;
                endcase
            end
            3'd3: alu_comb = a & b;
            3'd4: alu_comb = a | b;
            3'd5: alu_comb = WIDTH'($signed(a) < $signed(b));
            3'd6: alu_comb = a ^ b;
            3'd7: alu_comb = b << 16;
            default: alu_comb = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    localparam int CW = $clog2(MUL_ITERS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic               mult_sel;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;
    logic [WIDTH:0]     upper_ext;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   prod_lo;
    logic [CW-1:0]      count;
    logic               last_step;

    assign mult_sel  = (bus.ALUOp == 3'd2) && (bus.funct == 6'h18);
    assign last_step = (count == CW'(MUL_ITERS - 1));

    // Add/sub done one bit wider so M = -2^WIDTH-1 cannot overflow before the shift.
    assign upper_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    assign mcand_ext = {mcand[WIDTH-1], mcand};

    always_comb begin
        sum = upper_ext;
        case (acc[1:0])
            2'b01:   sum = upper_ext + mcand_ext;
            2'b10:   sum = upper_ext - mcand_ext;
            default: sum = upper_ext;
        endcase
        acc_step = {sum, acc[WIDTH:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            prod_lo <= '0;
            count   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && mult_sel) begin
                acc   <= {{WIDTH{1'b0}}, bus.AluReadData2, 1'b0};
                mcand <= bus.AluReadData1;
                count <= '0;
            end else if (state == BUSY && mult_sel) begin
                acc   <= acc_step;
                count <= count + 1'b1;
                if (last_step)
                    prod_lo <= acc_step[WIDTH:1];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mult_sel) state_nx = BUSY;
            BUSY:    if (!mult_sel) state_nx = IDLE;
                     else if (last_step) state_nx = DONE;
            DONE:    if (!mult_sel) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign result   = mult_sel ? ((state == DONE) ? prod_lo : '0) : alu_comb;
    assign bus.Busy = mult_sel && (state != DONE) && !rst;
`else
    logic unused_mul;

    assign unused_mul = &{1'b0, clk, rst, MUL_ITERS[0]};
    assign result     = alu_comb;
    assign bus.Busy   = 1'b0;
`endif

    assign bus.ALUResult = result;
    assign bus.Zero      = (result == '0);
endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - directed self-checking bench for the execute stage
module tb_execute;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    execute_if #(.WIDTH(32)) bus ();

    execute dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [5:0] f, input logic [2:0] op, input logic src);
        @(negedge clk);
        bus.AluReadData1 = a;
        bus.AluReadData2 = b;
        bus.Immediate    = imm;
        bus.funct        = f;
        bus.ALUOp        = op;
        bus.ALUSrc       = src;
        #1;
    endtask

    task automatic alu(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [5:0] f, input logic [2:0] op,
                       input logic src, input logic [31:0] exp);
        drive(a, b, imm, f, op, src);
        check(tag, bus.ALUResult, exp);
        check({tag, "_zero"}, {31'b0, bus.Zero}, {31'b0, exp == 32'd0});
    endtask

`ifdef EXECUTE_MUL_EN
    task automatic mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit disturb);
        int cnt;
        drive(a, b, 32'h0, 6'h18, 3'd2, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.Busy) break;
            cnt++;
            @(negedge clk);
            if (disturb && cnt == 5) begin
                bus.AluReadData1 = 32'd100;
                bus.AluReadData2 = 32'd9;
            end
            #1;
        end
        check({tag, "_busy_cycles"}, cnt, 32'd33);
        check({tag, "_result"}, bus.ALUResult, exp);
        drive(32'h0, 32'h0, 32'h0, 6'h0, 3'd0, 1'b0);
        check({tag, "_busy_after"}, {31'b0, bus.Busy}, 32'd0);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.AluReadData1 = '0;
        bus.AluReadData2 = '0;
        bus.Immediate    = '0;
        bus.funct        = '0;
        bus.ALUOp        = '0;
        bus.ALUSrc       = 1'b0;
        #1;
        check("reset_busy", {31'b0, bus.Busy}, 32'd0);
        check("reset_result", bus.ALUResult, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        alu("add",        32'd3, 32'd4, 32'h0, 6'h00, 3'd0, 1'b0, 32'd7);
        alu("add_fn1",    32'd3, 32'd4, 32'h0, 6'h01, 3'd0, 1'b0, 32'd7);
        alu("addi_neg",   32'd3, 32'd4, 32'hFFFFFFFF, 6'h00, 3'd0, 1'b1, 32'd2);
        alu("andi",       32'd3, 32'd4, 32'hFFFFFFFF, 6'h00, 3'd3, 1'b1, 32'd3);
        alu("subi",       32'd3, 32'd4, 32'hFFFFFFFF, 6'h00, 3'd1, 1'b1, 32'd4);
        alu("beq_eq",     32'd5, 32'd5, 32'h0, 6'h00, 3'd1, 1'b0, 32'd0);
        alu("slt_op",     32'hFFFFFFFF, 32'd1, 32'h0, 6'h00, 3'd5, 1'b0, 32'd1);
        alu("or_op",      32'h0F0F0000, 32'h000000F0, 32'h0, 6'h00, 3'd4, 1'b0, 32'h0F0F00F0);
        alu("xor_op",     32'hFF00FF00, 32'h0FF00FF0, 32'h0, 6'h00, 3'd6, 1'b0, 32'hF0F0F0F0);
        alu("lui",        32'h0, 32'h0, 32'hABCD1234, 6'h00, 3'd7, 1'b1, 32'h12340000);
        alu("add_wrap",   32'hFFFFFFFF, 32'd1, 32'h0, 6'h00, 3'd0, 1'b0, 32'd0);
        alu("r_nor",      32'd0, 32'd0, 32'h0, 6'h27, 3'd2, 1'b0, 32'hFFFFFFFF);
        alu("r_sltu",     32'hFFFFFFFF, 32'd1, 32'h0, 6'h2B, 3'd2, 1'b0, 32'd0);
        alu("r_slt",      32'hFFFFFFFF, 32'd1, 32'h0, 6'h2A, 3'd2, 1'b0, 32'd1);
        alu("r_addu",     32'd10, 32'd20, 32'h0, 6'h21, 3'd2, 1'b0, 32'd30);
        alu("r_sub",      32'd10, 32'd20, 32'h0, 6'h22, 3'd2, 1'b0, 32'hFFFFFFF6);
        alu("r_and",      32'hF0F0F0F0, 32'h3C3C3C3C, 32'h0, 6'h24, 3'd2, 1'b0, 32'h30303030);
        alu("r_or",       32'hF0F0F0F0, 32'h0000000F, 32'h0, 6'h25, 3'd2, 1'b0, 32'hF0F0F0FF);
        alu("r_xor",      32'hAAAA5555, 32'hFFFF0000, 32'h0, 6'h26, 3'd2, 1'b0, 32'h55555555);
        alu("r_unknown",  32'd7, 32'd9, 32'h0, 6'h3F, 3'd2, 1'b0, 32'd0);

`ifdef EXECUTE_MUL_EN
        mult("mul_m3x7", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b1);
        mult("mul_min_min", 32'h80000000, 32'h80000000, 32'h00000000, 1'b0);
        mult("mul_min_neg1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        drive(32'd12, 32'd12, 32'h0, 6'h18, 3'd2, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, bus.Busy}, 32'd0);
        bus.ALUOp = 3'd0;
        bus.funct = 6'h00;
        #1;
        rst = 1'b0;
        mult("mul_6x7", 32'd6, 32'd7, 32'd42, 1'b0);
`else
        drive(32'hFFFFFFFD, 32'd7, 32'h0, 6'h18, 3'd2, 1'b0);
        check("nomul_result", bus.ALUResult, 32'd0);
        check("nomul_zero", {31'b0, bus.Zero}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("nomul_busy", {31'b0, bus.Busy}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
